// File: rtl/seven_seg_msg_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_msg_ctrl
//
// Owns an 8-digit multiplexed seven-segment display and puts a message on it.
// A producer streams segment patterns in through a valid/ready write port.
// A message that fits on the display is shown statically, left-aligned.
// A longer message scrolls circularly, one character per scroll period.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   wr_valid     producer offers wr_char this cycle
//   wr_ready     block accepts a character this cycle
//   wr_char      segment pattern, bit 7 = a ... bit 0 = h
//   wr_last      wr_char is the final character of the message
//   clear        abandon the message and return to IDLE
//   active       a message is on the display (SHOW or SCROLL)
//   scroll_wrap  one-cycle pulse when the scroll offset wraps back to 0
//   abcdefgh     registered segment drive for the selected digit
//   digit        registered one-hot digit select, MSB = leftmost digit
// ---------------------------------------------------------------------------
module seven_seg_msg_ctrl #(
    parameter int w_digit       = 8,
    parameter int max_len       = 16,
    parameter int scan_div_w    = 17,
    parameter int scroll_period = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [7:0]         wr_char,
    input  logic               wr_last,
    input  logic               clear,
    output logic               active,
    output logic               scroll_wrap,
    output logic [7:0]         abcdefgh,
    output logic [w_digit-1:0] digit
);

    localparam int len_w  = $clog2(max_len + 1);
    localparam int off_w  = $clog2(max_len);
    localparam int addr_w = off_w;
    localparam int pos_w  = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int sum_w  = $clog2(max_len + w_digit) + 1;
    localparam int scr_w  = $clog2(scroll_period + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW,
        SCROLL
    } state_t;

    state_t                state, state_n;
    logic [len_w-1:0]      len, len_n;
    logic [off_w-1:0]      offset, offset_n;
    logic [scr_w-1:0]      scroll_cnt, scroll_cnt_n;
    logic [scan_div_w-1:0] scan_cnt;
    logic                  scroll_wrap_n;
    logic [w_digit-1:0]    digit_n;
    logic [7:0]            seg_n;
    logic                  xfer;

    logic [7:0]            msg_buf [max_len];

    // A clear arriving with a character wins, so the port refuses that
    // character rather than accepting and then discarding it.
    assign wr_ready = ((state == IDLE) || (state == LOAD)) && !clear;
    assign xfer     = wr_valid && wr_ready;
    assign active   = (state == SHOW) || (state == SCROLL);

    // Message storage. Contents are never reset because only the first
    // len entries are ever read.
    always_ff @(posedge clk) begin
        if (!rst && xfer) begin
            msg_buf[len[addr_w-1:0]] <= wr_char;
        end
    end

    // Next-state logic for the message sequencer: loading, the choice
    // between static and scrolling display, and the scroll offset stepping.
    always_comb begin
        state_n       = state;
        len_n         = len;
        offset_n      = offset;
        scroll_cnt_n  = scroll_cnt;
        scroll_wrap_n = 1'b0;
        if (clear) begin
            state_n      = IDLE;
            len_n        = '0;
            offset_n     = '0;
            scroll_cnt_n = '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (xfer) begin
                        len_n = len + 1'b1;
                        if (wr_last || (len_n == len_w'(max_len))) begin
                            state_n      = (len_n <= len_w'(w_digit)) ? SHOW : SCROLL;
                            offset_n     = '0;
                            scroll_cnt_n = '0;
                        end else begin
                            state_n = LOAD;
                        end
                    end
                end
                SCROLL: begin
                    if (scroll_cnt == scr_w'(scroll_period - 1)) begin
                        scroll_cnt_n = '0;
                        if (len_w'(offset) == (len - 1'b1)) begin
                            offset_n      = '0;
                            scroll_wrap_n = 1'b1;
                        end else begin
                            offset_n = offset + 1'b1;
                        end
                    end else begin
                        scroll_cnt_n = scroll_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Digit scan and segment lookup. The segment pattern is computed for the
    // digit that will be selected after this edge, so both registers change
    // together. The character written on the final load edge is not in the
    // buffer yet, so it is forwarded straight from wr_char.
    always_comb begin
        logic [pos_w-1:0] k;
        logic [pos_w-1:0] p;
        logic [sum_w-1:0] sum;
        logic [addr_w-1:0] idx;

        digit_n = digit;
        if (scan_cnt == '1) begin
            digit_n = {digit[0], digit[w_digit-1:1]};
        end

        k = '0;
        for (int i = 0; i < w_digit; i++) begin
            if (digit_n[i]) begin
                k = pos_w'(i);
            end
        end
        p = pos_w'(w_digit - 1) - k;

        sum   = '0;
        idx   = '0;
        seg_n = 8'h00;
        case (state_n)
            SHOW: begin
                if (len_w'(p) < len_n) begin
                    idx   = addr_w'(p);
                    seg_n = (xfer && (idx == len[addr_w-1:0])) ? wr_char : msg_buf[idx];
                end
            end
            SCROLL: begin
                // offset < len and p < len, so one conditional subtract
                // is enough to wrap the index into the message.
                sum = sum_w'(offset_n) + sum_w'(p);
                if (sum >= sum_w'(len_n)) begin
                    sum = sum - sum_w'(len_n);
                end
                idx   = sum[addr_w-1:0];
                seg_n = (xfer && (idx == len[addr_w-1:0])) ? wr_char : msg_buf[idx];
            end
            default: begin
            end
        endcase
    end

    // State register for the sequencer, scan counter and display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            offset      <= '0;
            scroll_cnt  <= '0;
            scan_cnt    <= '0;
            digit       <= w_digit'(1);
            abcdefgh    <= 8'h00;
            scroll_wrap <= 1'b0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            offset      <= offset_n;
            scroll_cnt  <= scroll_cnt_n;
            scan_cnt    <= scan_cnt + 1'b1;
            digit       <= digit_n;
            abcdefgh    <= seg_n;
            scroll_wrap <= scroll_wrap_n;
        end
    end

endmodule

// File: tb/tb_seven_seg_msg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_msg_ctrl
//
// Scoreboard bench for seven_seg_msg_ctrl with scan_div_w=2 and
// scroll_period=8. A reference model tracks the message as a byte queue and
// derives the selected digit and scroll offset from elapsed cycle counts.
// Every cycle it pushes the expected outputs; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_seven_seg_msg_ctrl;

    localparam int W_DIG  = 8;
    localparam int MAXL   = 16;
    localparam int SCAN_W = 2;
    localparam int SCROLL = 8;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_char;
    logic       wr_last;
    logic       clear;
    logic       active;
    logic       scroll_wrap;
    logic [7:0] abcdefgh;
    logic [7:0] digit;

    typedef struct {
        logic [7:0] digit;
        logic [7:0] seg;
        logic       active;
        logic       ready;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 idle, 1 loading, 2 static, 3 scrolling.
    int              m_mode   = 0;
    int              m_cyc    = 0;
    int              m_scroll = 0;
    bit              m_valid  = 0;
    logic [7:0]      m_msg[$];

    seven_seg_msg_ctrl #(
        .w_digit      (W_DIG),
        .max_len      (MAXL),
        .scan_div_w   (SCAN_W),
        .scroll_period(SCROLL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_char    (wr_char),
        .wr_last    (wr_last),
        .clear      (clear),
        .active     (active),
        .scroll_wrap(scroll_wrap),
        .abcdefgh   (abcdefgh),
        .digit      (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison with counting and reporting.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; they change 1 time unit after the edge.
    task automatic applyStimulus(input bit v, input logic [7:0] ch, input bit last,
                                 input bit clr, input bit r);
        wr_valid = v;
        wr_char  = ch;
        wr_last  = last;
        clear    = clr;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Loads n random characters, wr_last on the final one when requested.
    task automatic loadRandom(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 8'($urandom), with_last && (i == n - 1), 1'b0, 1'b0);
        end
    endtask

    // Model update at each clock edge from the inputs seen at that edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1;
            m_mode   = 0;
            m_cyc    = 0;
            m_scroll = 0;
            m_msg.delete();
        end else if (m_valid) begin
            m_cyc++;
            if (clear) begin
                m_mode   = 0;
                m_scroll = 0;
                m_msg.delete();
            end else if (m_mode <= 1 && wr_valid) begin
                m_msg.push_back(wr_char);
                if (wr_last || m_msg.size() == MAXL) begin
                    m_mode   = (m_msg.size() <= W_DIG) ? 2 : 3;
                    m_scroll = 0;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 3) begin
                m_scroll++;
            end
        end
    end

    // Expected outputs for the cycle, pushed once per cycle.
    always @(negedge clk) begin
        exp_t e;
        int   p;
        int   off;
        int   n;
        if (m_valid) begin
            p   = ((m_cyc / (1 << SCAN_W)) + W_DIG - 1) % W_DIG;
            n   = m_msg.size();
            off = (n > 0) ? (m_scroll / SCROLL) % n : 0;
            e.digit  = 8'd1 << (W_DIG - 1 - p);
            e.active = (m_mode >= 2);
            e.ready  = (m_mode <= 1) && !clear;
            e.wrap   = (m_mode == 3) && (m_scroll > 0) && (m_scroll % SCROLL == 0)
                       && ((m_scroll / SCROLL) % n == 0);
            if (m_mode == 2)      e.seg = (p < n) ? m_msg[p] : 8'h00;
            else if (m_mode == 3) e.seg = m_msg[(off + p) % n];
            else                  e.seg = 8'h00;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares the DUT against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("digit",       32'(digit),       32'(e.digit));
            checkOutput("abcdefgh",    32'(abcdefgh),    32'(e.seg));
            checkOutput("active",      32'(active),      32'(e.active));
            checkOutput("wr_ready",    32'(wr_ready),    32'(e.ready));
            checkOutput("scroll_wrap", 32'(scroll_wrap), 32'(e.wrap));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset held for three clocks, then free-running scan in IDLE.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(12);

        // Short static message.
        applyStimulus(1'b1, 8'h9E, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hBC, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFC, 1'b1, 1'b0, 1'b0);
        idle(40);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Ten characters, scrolling through more than two full wraps.
        loadRandom(10, 1'b1);
        idle(200);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Buffer-full termination, then a held-off extra character.
        loadRandom(16, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        idle(150);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Clear in LOAD together with a write; the write must be dropped.
        loadRandom(4, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        idle(3);
        loadRandom(2, 1'b1);
        idle(40);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of loading, then a fresh short message.
        loadRandom(5, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        loadRandom(2, 1'b1);
        idle(40);

        // Random messages with gaps, random termination and random clears.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, MAXL);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
                applyStimulus(1'b1, 8'($urandom), (i == n - 1) && ($urandom_range(0, 3) != 0),
                              1'b0, 1'b0);
            end
            idle($urandom_range(60, 160));
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            idle(2);
        end

        idle(2);
        @(negedge clk);
        #3;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
